// File: rtl/charlie_frame_ctrl.sv
// charlie_frame_ctrl: double-buffered 8x8 frame controller for the charlieplex
// scan driver. The writer fills a back buffer row by row and commits it. The
// front buffer is replaced only on a scan boundary, and only after the current
// frame has been shown for at least the committed hold count.
// Optional build macro: CHARLIE_CTRL_CLEAR_EN clears the back buffer on swap.
module charlie_frame_ctrl #(
  parameter int DONE_INDEX = 63,
  parameter int HOLD_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_row,
  input  logic [7:0]        wr_data,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [HOLD_W-1:0] hold,
  input  logic              scan_done,
  output logic [63:0]       frame_buffer,
  output logic [5:0]        frame_done_index,
  output logic              swap_pulse,
  output logic [7:0]        frame_count
);

  typedef enum logic {FILL, PENDING} state_t;

  state_t            state, state_nxt;
  logic [63:0]       back, front;
  logic [HOLD_W-1:0] shown_cnt, hold_q;
  logic [HOLD_W:0]   shown_inc, hold_eff;
  logic              wr_fire, commit_fire, swap;

  // One extra bit so the saturated count plus one cannot wrap in the compare;
  // a zero hold is treated as a single scan.
  assign shown_inc   = {1'b0, shown_cnt} + {{HOLD_W{1'b0}}, 1'b1};
  assign hold_eff    = (hold_q == '0) ? {{HOLD_W{1'b0}}, 1'b1} : {1'b0, hold_q};
  assign wr_fire     = wr_valid & wr_ready;
  assign commit_fire = commit_valid & commit_ready;

  assign frame_buffer     = front;
  assign frame_done_index = 6'(DONE_INDEX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state, handshake readies and swap decision.
  always_comb begin
    state_nxt    = state;
    wr_ready     = 1'b0;
    commit_ready = 1'b0;
    swap         = 1'b0;
    case (state)
      FILL: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
        if (commit_valid) state_nxt = PENDING;
      end
      PENDING: begin
        if (scan_done && (shown_inc >= hold_eff)) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Back buffer: row writes in FILL; optionally blanked when it is displayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      back <= '0;
`ifdef CHARLIE_CTRL_CLEAR_EN
    end else if (swap) begin
      back <= '0;
`else
`endif
    end else if (wr_fire) begin
      back[{wr_row, 3'b000} +: 8] <= wr_data;
    end
  end

  // Hold count latched when the commit is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              hold_q <= '0;
    else if (commit_fire) hold_q <= hold;
  end

  // Scans shown since the last swap; saturates so long idles still qualify.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   shown_cnt <= '0;
    else if (swap)                             shown_cnt <= '0;
    else if (scan_done && (shown_cnt != '1))   shown_cnt <= shown_cnt + 1'b1;
  end

  // Front buffer, swap strobe and frame counter update on the swap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front       <= '0;
      swap_pulse  <= 1'b0;
      frame_count <= '0;
    end else begin
      swap_pulse <= swap;
      if (swap) begin
        front       <= back;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_charlie_frame_ctrl.sv
// Directed bench for charlie_frame_ctrl. A back-buffer model feeds a queue of
// expected frames at each commit; a monitor pops and compares on swap_pulse.
module tb_charlie_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready, commit_valid, commit_ready, scan_done, swap_pulse;
  logic [2:0]  wr_row;
  logic [7:0]  wr_data, frame_count;
  logic [3:0]  hold;
  logic [63:0] frame_buffer;
  logic [5:0]  frame_done_index;

  typedef struct {
    logic [63:0] frame;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mback;
  logic [7:0]  ncnt;
  logic        prev_pulse;
  int          errors = 0;
  int          checks = 0;

  charlie_frame_ctrl #(.DONE_INDEX(63), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .hold(hold),
    .scan_done(scan_done), .frame_buffer(frame_buffer),
    .frame_done_index(frame_done_index), .swap_pulse(swap_pulse),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_valid = 1'b1; wr_row = r; wr_data = d;
    tick;
    mback[{r, 3'b000} +: 8] = d;
    wr_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] h);
    commit_valid = 1'b1; hold = h;
    tick;
    ncnt = ncnt + 8'd1;
    q.push_back('{frame: mback, cnt: ncnt});
    commit_valid = 1'b0;
  endtask

  task automatic scan(input int gap);
    scan_done = 1'b1;
    tick;
    scan_done = 1'b0;
    repeat (gap) tick;
  endtask

  // Scoreboard monitor: every swap must match the oldest committed frame.
  always @(negedge clk) begin
    if (swap_pulse) begin
      checks++;
      assert (!prev_pulse) else begin
        errors++;
        $error("FAIL swap_pulse_width observed=2+ cycles expected=1 cycle");
      end
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_swap observed=swap expected=none pending");
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_frame", frame_buffer, e.frame);
        chk("sb_count", 64'(frame_count), 64'(e.cnt));
`ifdef CHARLIE_CTRL_CLEAR_EN
        mback = '0;
`endif
      end
    end
    prev_pulse = swap_pulse;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_row = '0; wr_data = '0;
    commit_valid = 1'b0; hold = '0; scan_done = 1'b0;
    mback = '0; ncnt = '0; prev_pulse = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;

    // Reset / idle state
    chk("rst_frame", frame_buffer, 64'h0);
    chk("rst_count", 64'(frame_count), 64'h0);
    chk("rst_wr_ready", 64'(wr_ready), 64'h1);
    chk("rst_commit_ready", 64'(commit_ready), 64'h1);
    chk("rst_done_index", 64'(frame_done_index), 64'd63);
    chk("rst_swap_pulse", 64'(swap_pulse), 64'h0);

    // Walking-one frame, hold=1, swaps on first scan
    for (int i = 0; i < 8; i++) write_row(3'(i), 8'(1 << i));
    commit(4'd1);
    chk("t1_back_hidden", frame_buffer, 64'h0);
    scan(0);
    chk("t1_frame", frame_buffer, 64'h8040201008040201);
    chk("t1_pulse", 64'(swap_pulse), 64'h1);
    chk("t1_count", 64'(frame_count), 64'd1);
    tick;
    chk("t1_pulse_drop", 64'(swap_pulse), 64'h0);
    chk("t1_wr_ready", 64'(wr_ready), 64'h1);

    // hold=3 right after a swap; writes in PENDING are ignored
    write_row(3'd0, 8'h55);
    commit(4'd3);
    chk("t2_wr_ready_pend", 64'(wr_ready), 64'h0);
    chk("t2_commit_ready_pend", 64'(commit_ready), 64'h0);
    wr_valid = 1'b1; wr_row = 3'd2; wr_data = 8'hFF;
    commit_valid = 1'b1; hold = 4'd0;
    scan(63);
    chk("t2_noswap1", 64'(frame_count), 64'd1);
    scan(63);
    chk("t2_noswap2", 64'(frame_count), 64'd1);
    chk("t2_still_pend", 64'(wr_ready), 64'h0);
    wr_valid = 1'b0; commit_valid = 1'b0;
    scan(0);
    chk("t2_frame", frame_buffer, 64'h8040201008040255);
    chk("t2_count", 64'(frame_count), 64'd2);
    tick;

    // Simultaneous write and commit
    wr_valid = 1'b1; wr_row = 3'd5; wr_data = 8'hAA;
    commit_valid = 1'b1; hold = 4'd1;
    tick;
    mback[47:40] = 8'hAA;
    ncnt = ncnt + 8'd1;
    q.push_back('{frame: mback, cnt: ncnt});
    wr_valid = 1'b0; commit_valid = 1'b0;
    tick;
    scan(1);
    chk("t3_row5", 64'(frame_buffer[47:40]), 64'hAA);
    chk("t3_count", 64'(frame_count), 64'd3);
    commit(4'd1);
    scan(1);
`ifdef CHARLIE_CTRL_CLEAR_EN
    chk("t3_back_after", frame_buffer, 64'h0);
`else
    chk("t3_back_after", 64'(frame_buffer[47:40]), 64'hAA);
`endif

    // Long idle saturates shown_cnt; hold=4 swaps on the next scan
    repeat (20) scan(3);
    chk("t4_idle_count", 64'(frame_count), 64'd4);
    write_row(3'd3, 8'h3C);
    commit(4'd4);
    scan(1);
    chk("t4_count", 64'(frame_count), 64'd5);
    chk("t4_row3", 64'(frame_buffer[31:24]), 64'h3C);

    // Reset mid-PENDING abandons the commit
    write_row(3'd7, 8'hE7);
    commit(4'd2);
    scan(1);
    chk("t5_pend_count", 64'(frame_count), 64'd5);
    chk("t5_pend", 64'(wr_ready), 64'h0);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_frame", frame_buffer, 64'h0);
    chk("t5_rst_count", 64'(frame_count), 64'h0);
    chk("t5_rst_pulse", 64'(swap_pulse), 64'h0);
    chk("t5_rst_wr_ready", 64'(wr_ready), 64'h1);
    chk("t5_rst_commit_ready", 64'(commit_ready), 64'h1);
    q.delete(); mback = '0; ncnt = '0;
    tick;
    rst = 1'b0;
    tick;
    scan(1);
    scan(1);
    chk("t5_no_swap", 64'(frame_count), 64'h0);
    commit(4'd1);
    scan(1);
    chk("t5_back_cleared", frame_buffer, 64'h0);
    chk("t5_count", 64'(frame_count), 64'd1);

    repeat (2) tick;
    chk("drain_queue", 64'(q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/charlie_frame_ctrl.md
# charlie_frame_ctrl

Double-buffered frame controller that feeds the 8x8 charlieplex scan driver. A writer fills a back buffer row by row, then commits it. The block swaps the back buffer into the displayed front buffer only on a scan-frame boundary, and only after the current frame has been shown for a programmable number of scans. This prevents tearing and enforces a minimum frame duration.

## Interface
Parameters:
- DONE_INDEX, 63: scan index reported to the driver as the end-of-frame position; drives `frame_done_index`.
- HOLD_W, 4: width of the per-frame hold count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  row write request.
- wr_ready  output  1  row write accepted when high together with wr_valid.
- wr_row  input  3  target row 0..7 of the back buffer.
- wr_data  input  8  row bits; bit c = column c.
- commit_valid  input  1  request to display the back buffer.
- commit_ready  output  1  commit accepted when high together with commit_valid.
- hold  input  HOLD_W  minimum scans the current front frame is shown before the swap; sampled at commit acceptance.
- scan_done  input  1  end-of-scan strobe from the driver (its is_frame_done).
- frame_buffer  output  64  front buffer to the driver; row r = bits [8r+7:8r].
- frame_done_index  output  6  constant DONE_INDEX[5:0].
- swap_pulse  output  1  high for exactly one cycle after a swap edge.
- frame_count  output  8  number of swaps since reset, wraps 255->0.

## Operation
- State machine with states FILL and PENDING. Reset state is FILL.
- FILL:
  - wr_ready=1 and commit_ready=1.
  - A write handshake stores wr_data into back[8*wr_row +: 8] on that edge.
  - A commit handshake latches hold into hold_q and moves to PENDING.
  - A write and a commit in the same cycle: the write lands and is part of the committed frame.
- PENDING:
  - wr_ready=0 and commit_ready=0; wr_valid and commit_valid are ignored.
  - On a cycle with scan_done=1 and shown_cnt+1 >= max(hold_q,1), perform the swap on that edge:
    - front <= back
    - shown_cnt <= 0
    - frame_count <= frame_count+1
    - swap_pulse <= 1 (next cycle)
    - state <= FILL
  - hold_q=0 behaves as 1.
- shown_cnt (HOLD_W bits) counts scan_done cycles since the last swap, in both states. It saturates at all-ones and never wraps.
  - A commit made long after the last swap therefore swaps at the first scan_done once shown_cnt has already reached hold_q.
- Each cycle with scan_done=1 counts as one scan; scan_done is not edge-detected.
- The back buffer persists across swaps unless the clear feature is compiled in (see Configuration).
- frame_buffer is driven directly from the front register, with no extra logic.

Reset values:
- Both buffers 0.
- frame_buffer 0, shown_cnt 0, hold_q 0, frame_count 0, swap_pulse 0.
- wr_ready 1 and commit_ready 1 (FILL).

Reset asserted mid-PENDING abandons the commit. The back buffer is cleared to 0.

## Timing
- Write latency: data is in back one edge after the handshake. It is not visible on frame_buffer until a swap.
- Swap latency: frame_buffer changes on the edge that samples the qualifying scan_done.
  - With DONE_INDEX=63, the driver's next scan index 0 already sees the new frame. No partial frame is ever displayed.
- swap_pulse and the FILL re-entry (wr_ready=1) are visible in the cycle after the swap edge.
- Minimum commit-to-swap latency is 0 cycles of wait beyond the qualifying scan_done. The worst case is hold_q scans.
- frame_done_index is static and has no latency.

## Configuration
- Macro `CHARLIE_CTRL_CLEAR_EN`.
- Defined: on the swap edge the back buffer is also cleared to 0, so every frame is written from blank.
- Undefined: the back buffer keeps its contents after a swap, so the writer may update only changed rows.
- A write cannot coincide with a swap, because wr_ready=0 in PENDING.

## Test plan
- Reset then idle: frame_buffer=0, frame_count=0, wr_ready=1, commit_ready=1, frame_done_index=63.
- Write rows 0..7 = 8'h01,02,04,..,80, commit with hold=1, pulse scan_done once: frame_buffer=64'h8040201008040201 on that edge, swap_pulse=1 the next cycle, frame_count=1.
- Commit with hold=3 immediately after a swap, pulse scan_done 3 times at 64-cycle spacing: no swap after pulses 1 and 2, swap on pulse 3. wr_valid asserted during PENDING is not accepted (wr_ready=0, back unchanged).
- Simultaneous write and commit (row 5 = 8'hAA): after the swap, frame_buffer[47:40]=8'hAA. With `CHARLIE_CTRL_CLEAR_EN`, back reads 0 afterwards; without it, back[47:40] stays 8'hAA.
- Idle 20 scans without a commit, then commit with hold=4: the swap occurs at the next scan_done (shown_cnt saturated at 15).
- Assert rst mid-PENDING: all outputs return to their reset values asynchronously. No swap occurs on the following scan_done without a new commit.
